// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_hs
//  Purpose  : Handshaked pipeline stage register with flush, zeroed bubbles
//             and a saturating back-pressure counter. Defining
//             PIPE_STAGE_SKID_EN selects the two-slot form with registered
//             in_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_hs #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    if (WIDTH < 1) begin : g_width_check
        $error("pipe_stage_hs: WIDTH must be >= 1");
    end
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("pipe_stage_hs: CNT_W must be >= 1");
    end

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_main_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    // Ready comes only from the skid flop, so stall chains never ripple back.
    assign in_ready = !flush && !r_skid_valid;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_out_fire) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
                r_skid_data  <= '0;
            end else if (w_in_fire) begin
                r_main_valid <= 1'b1;
                r_main_data  <= in_data;
            end else begin
                r_main_valid <= 1'b0;
                r_main_data  <= '0;
            end
        end else if (w_in_fire) begin
            if (!r_main_valid) begin
                r_main_valid <= 1'b1;
                r_main_data  <= in_data;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= in_data;
            end
        end
    end
`else
    assign in_ready = !flush && (!r_main_valid || out_ready);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
        end else if (w_in_fire) begin
            r_main_valid <= 1'b1;
            r_main_data  <= in_data;
        end else if (w_out_fire) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
        end
    end
`endif

    // Flush cycles are not back-pressure, and flush never clears the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && !flush && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// Testbench for pipe_stage_hs: directed scenarios plus a randomized stream,
// checked against a FIFO-based reference model.
module tb_pipe_stage_hs;

    localparam int W    = 32;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          flush;
    logic [CW-1:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pipe_stage_hs #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the stage behaves as a FIFO of DEPTH beats.
    logic [W-1:0] mq[$];
    int           m_cnt;

    function automatic logic m_ready();
`ifdef PIPE_STAGE_SKID_EN
        return !flush && (mq.size() < DEPTH);
`else
        return !flush && (mq.size() == 0 || out_ready);
`endif
    endfunction

    function automatic logic m_valid();
        return mq.size() > 0;
    endfunction

    function automatic logic [W-1:0] m_head();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    task automatic tick();
        logic         inf, outf, stall;
        logic [W-1:0] d;
        inf   = in_valid && m_ready();
        outf  = m_valid() && out_ready;
        stall = m_valid() && !out_ready && !flush;
        d     = in_data;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            if (stall && m_cnt < CMAX) m_cnt++;
            if (outf) void'(mq.pop_front());
            if (flush) mq.delete();
            else if (inf) mq.push_back(d);
        end
        #1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0; #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_total++; if (stall_cnt !== '0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1; in_data = 32'h1234; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; #1;
        n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (out_data !== 32'h1234) $display("FAIL single_data: got %h want 1234", out_data); else n_pass++;
        n_total++; if (stall_cnt !== '0) $display("FAIL single_stall: got %0d want 0", stall_cnt); else n_pass++;
        idle(2);
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            in_valid = (i <= 8);
            in_data  = W'(i);
            #1;
            n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
            if (i > 1) begin
                n_total++;
                if (out_valid !== 1'b1 || out_data !== W'(i - 1))
                    $display("FAIL b2b_out[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, i - 1);
                else n_pass++;
            end
            tick();
        end
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
`ifdef PIPE_STAGE_SKID_EN
            in_valid = (i == 0); in_data = 32'hB;
`else
            in_valid = 1'b0;
`endif
            tick();
`ifdef PIPE_STAGE_SKID_EN
            if (i == 0) begin
                #1;
                n_total++; if (in_ready !== 1'b0) $display("FAIL stall_skid_ready: got %b want 0", in_ready); else n_pass++;
            end
`endif
        end
        in_valid = 1'b0; #1;
        n_total++; if (stall_cnt !== CW'(5)) $display("FAIL stall_cnt5: got %0d want 5", stall_cnt); else n_pass++;
        out_ready = 1'b1; #1;
        n_total++; if (out_data !== 32'hA) $display("FAIL stall_first: got %h want a", out_data); else n_pass++;
        tick();
`ifdef PIPE_STAGE_SKID_EN
        n_total++; if (out_valid !== 1'b1 || out_data !== 32'hB) $display("FAIL stall_second: got v=%b d=%h want v=1 d=b", out_valid, out_data); else n_pass++;
        tick();
`endif
        n_total++; if (out_valid !== 1'b0) $display("FAIL stall_drained: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0;
        tick();
`ifdef PIPE_STAGE_SKID_EN
        in_data = 32'hB;
        tick();
`endif
        flush = 1'b1; in_data = 32'hC; #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready_during: got %b want 0", in_ready); else n_pass++;
        tick();
        flush = 1'b0; in_valid = 1'b0; #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL flush_data: got %h want 0", out_data); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready_after: got %b want 1", in_ready); else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (out_valid !== 1'b0) $display("FAIL flush_no_beat[%0d]: got %b want 0", i, out_valid); else n_pass++;
        end
    endtask

    task automatic test_saturate();
        do_reset();
        in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_total++; if (stall_cnt !== CW'(CMAX)) $display("FAIL sat_cnt: got %0d want %0d", stall_cnt, CMAX); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        n_total++; if (stall_cnt !== '0) $display("FAIL sat_reset: got %0d want 0", stall_cnt); else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] tx[$];
        logic [W-1:0] rx[$];
        int           cyc;
        int           bad;
        do_reset();
        cyc = 0;
        bad = 0;
        while (rx.size() < 1000 && cyc < 20000) begin
            in_valid  = (tx.size() < 1000) && ($urandom_range(3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(2) != 0);
            #1;
            if (out_valid !== m_valid() || out_data !== m_head() || in_ready !== m_ready()
                || stall_cnt !== CW'(m_cnt) || (!out_valid && out_data !== '0)) begin
                if (bad < 5)
                    $display("FAIL rand_cycle[%0d]: got v=%b d=%h r=%b c=%0d want v=%b d=%h r=%b c=%0d",
                             cyc, out_valid, out_data, in_ready, stall_cnt, m_valid(), m_head(), m_ready(), m_cnt);
                bad++;
            end
            if (in_valid && in_ready) tx.push_back(in_data);
            if (out_valid && out_ready) rx.push_back(out_data);
            tick();
            cyc++;
        end
        n_total++; if (bad != 0) $display("FAIL rand_model: got %0d bad cycles want 0", bad); else n_pass++;
        n_total++; if (rx.size() != 1000) $display("FAIL rand_count: got %0d beats want 1000", rx.size()); else n_pass++;
        bad = 0;
        for (int i = 0; i < rx.size() && i < tx.size(); i++)
            if (rx[i] !== tx[i]) bad++;
        n_total++; if (bad != 0 || tx.size() != rx.size()) $display("FAIL rand_order: got %0d mismatched beats, tx=%0d rx=%0d want 0", bad, tx.size(), rx.size()); else n_pass++;
    endtask

    initial begin
        m_cnt = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Generic handshaked pipeline stage register that replaces the per-stage hand-written latches (IF/ID/EX/MEM/WB) in the core. It carries an opaque WIDTH-bit payload under a valid/ready handshake, supports flush with zeroed bubbles, and counts back-pressure cycles for performance tuning. An optional skid entry registers the upstream ready so that long stall chains do not form a combinational path across the pipeline.

## Interface
- WIDTH, 64: payload width in bits; must be ≥1.
- CNT_W, 16: stall counter width; must be ≥1.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage accepts a beat this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  WIDTH  payload; all zero whenever out_valid=0.
- flush  in  1  kill every held beat and block acceptance this cycle.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Input fire: in_valid && in_ready. Output fire: out_valid && out_ready.
- The main slot drives out_valid and out_data. The stage stores data only while valid; a slot that empties is cleared to zero, so no bubble carries stale payload.
- Without skid (single slot):
  - in_ready = !flush && (!out_valid || out_ready).
  - On input fire, main loads in_data and the valid bit sets.
  - On output fire with no input fire, main clears to 0 and the valid bit clears.
- With skid (see Configuration): two slots, main and skid. in_ready = !flush && !skid_valid. This term is registered and depends on no input port except flush.
  - Output fire with skid valid: main←skid, skid clears.
  - Output fire, skid empty, input fire: main←in_data.
  - Output fire, skid empty, no input fire: main clears.
  - No output fire, input fire, main empty: main←in_data.
  - No output fire, input fire, main full: skid←in_data.
  - Beat order is preserved. A beat is never lost and never duplicated.
- flush=1: both slots clear to invalid/zero on the next edge. No input fire occurs that cycle. flush does not cancel an output fire in the same cycle, because downstream has already consumed that beat.
- stall_cnt increments by 1 on every cycle where out_valid && !out_ready && !flush, and holds at 2^CNT_W−1. Only reset clears it; flush does not.
- Priority: reset > flush > handshake updates.

## Timing
- Reset values: out_valid=0, out_data=0, stall_cnt=0, internal skid empty. in_ready=1 in the first cycle after reset when flush=0.
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N. Output is registered; no combinational path from in_data to out_data.
- Throughput: 1 beat/cycle sustained when out_ready=1.
- Without skid, in_ready depends combinationally on out_ready. With skid, in_ready drops exactly one cycle after the skid fills.
- Flush asserted for k cycles produces out_valid=0 starting at edge 1 and lasting at least k cycles. in_ready=0 throughout.
- Reset mid-operation discards all held beats at the next edge. stall_cnt returns to 0.

## Configuration
- PIPE_STAGE_SKID_EN defined: the two-slot skid form with registered in_ready, as described above.
- Not defined: the single-slot form with combinational in_ready. Functional beat sequence is identical; only the ready timing and storage differ.

## Test plan
- Reset, then in_valid=1 with in_data=0x1234 and out_ready=1 → out_valid=1, out_data=0x1234 one cycle later; stall_cnt=0.
- Stream 0x1..0x8 back-to-back with out_ready=1 → eight outputs in order on consecutive cycles, no gaps.
- Hold out_ready=0 for 5 cycles with one beat held → stall_cnt=5. With skid: a second beat 0xB is absorbed, in_ready falls, and releasing out_ready yields the first beat then 0xB.
- Pulse flush for 1 cycle while holding beats 0xA (and 0xB with skid) → next cycle out_valid=0, out_data=0, in_ready=1; neither beat ever appears at the output.
- CNT_W=3 with out_ready=0 for 10 cycles → stall_cnt saturates at 7. Reset then returns it to 0.
- Random valid/ready with 1000 beats, both macro settings → output sequence equals input sequence, out_data=0 whenever out_valid=0.
